// File: rtl/dma_ctrl_if.sv
// Bus bundle for dma_ctrl.
// Carries the master access port (req/grant/wr/addr/dout/din) and the
// configuration slave port (sel/wr/addr/din/dout).
//   master modport : the DMA controller side (drives m_req/m_wr/m_addr/m_dout
//                    and s_dout; receives m_grant/m_din and the slave access).
//   slave modport  : the system side (arbiter, memory, register host).
interface dma_ctrl_if;
    // Master access port
    logic        m_grant;
    logic [31:0] m_din;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;
    // Configuration slave port
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [31:0] s_din;
    logic [31:0] s_dout;

    modport master (
        input  m_grant,
        input  m_din,
        output m_req,
        output m_wr,
        output m_addr,
        output m_dout,
        input  s_sel,
        input  s_wr,
        input  s_addr,
        input  s_din,
        output s_dout
    );

    modport slave (
        output m_grant,
        output m_din,
        input  m_req,
        input  m_wr,
        input  m_addr,
        input  m_dout,
        output s_sel,
        output s_wr,
        output s_addr,
        output s_din,
        input  s_dout
    );
endinterface

// File: rtl/dma_ctrl.sv
// Single-channel DMA controller.
// Copies SIZE 32-bit words from SRC to DST, one read and one write per word,
// over a req/grant bus master port, then flags completion on interrupt.
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   bus       - dma_ctrl_if.master: master access port plus config slave port
//   interrupt - done AND interrupt enable
// Register map (s_addr[2:0]): 0 SRC, 1 DST, 2 SIZE, 3 START, 4 INT (W1C done),
// 5 INT_EN, 6 STATUS (busy), 7 reads 0. SRC/DST/SIZE/START ignore writes
// while a transfer is in progress.
module dma_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    dma_ctrl_if.master bus,
    output logic       interrupt
);

    localparam logic [2:0] RegSrc    = 3'd0;
    localparam logic [2:0] RegDst    = 3'd1;
    localparam logic [2:0] RegSize   = 3'd2;
    localparam logic [2:0] RegStart  = 3'd3;
    localparam logic [2:0] RegInt    = 3'd4;
    localparam logic [2:0] RegIntEn  = 3'd5;
    localparam logic [2:0] RegStatus = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRead,
        StRwait,
        StWrite,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] size_q, size_d;
    logic        int_en_q, int_en_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] wsrc_q, wsrc_d;
    logic [15:0] wdst_q, wdst_d;
    logic [15:0] wsize_q, wsize_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] s_dout_q, s_dout_d;

    logic        busy;
    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic        cfg_we;
    logic        start;
    logic        int_clr;
    logic [31:0] rd_data;

    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout;

    // Upper address and data bits are not decoded by this block.
    logic unused_bits;
    assign unused_bits = ^{bus.s_addr[15:3], bus.s_din[31:16]};

    assign busy    = (state_q != StIdle);
    assign reg_sel = bus.s_addr[2:0];
    assign wr_en   = bus.s_sel & bus.s_wr;
    assign rd_en   = bus.s_sel & ~bus.s_wr;
    assign cfg_we  = wr_en & ~busy;
    assign start   = cfg_we & (reg_sel == RegStart) & bus.s_din[0];
    assign int_clr = wr_en & (reg_sel == RegInt) & bus.s_din[0];

    // Configuration registers and completion flag.
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        size_d   = size_q;
        int_en_d = int_en_q;
        done_d   = done_q;

        if (cfg_we) begin
            case (reg_sel)
                RegSrc:  src_d  = bus.s_din[15:0];
                RegDst:  dst_d  = bus.s_din[15:0];
                RegSize: size_d = bus.s_din[15:0];
                default: ;
            endcase
        end

        if (wr_en && (reg_sel == RegIntEn)) begin
            int_en_d = bus.s_din[0];
        end

        // Completion in the same cycle as a W1C clear keeps done set.
        if (state_q == StDone) begin
            done_d = 1'b1;
        end else if (int_clr) begin
            done_d = 1'b0;
        end
    end

    // Registered slave read: data is presented the cycle after the select.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            RegSrc:    rd_data = {16'h0000, src_q};
            RegDst:    rd_data = {16'h0000, dst_q};
            RegSize:   rd_data = {16'h0000, size_q};
            RegInt:    rd_data = {31'b0, done_q};
            RegIntEn:  rd_data = {31'b0, int_en_q};
            RegStatus: rd_data = {31'b0, busy};
            default:   rd_data = '0;
        endcase
        s_dout_d = rd_en ? rd_data : s_dout_q;
    end

    // Transfer FSM: next state and master port outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wsrc_d  = wsrc_q;
        wdst_d  = wdst_q;
        wsize_d = wsize_q;
        buf_d   = buf_q;
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_dout  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d   = '0;
                    wsrc_d  = src_q;
                    wdst_d  = dst_q;
                    wsize_d = size_q;
                    state_d = (size_q == 16'd0) ? StDone : StReq;
                end
            end
            StReq: begin
                m_req = 1'b1;
                if (bus.m_grant) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                m_req  = 1'b1;
                m_addr = wsrc_q + cnt_q;
                if (bus.m_grant) begin
                    state_d = StRwait;
                end
            end
            StRwait: begin
                // Read data returns one cycle after the granted address.
                m_req   = 1'b1;
                buf_d   = bus.m_din;
                state_d = StWrite;
            end
            StWrite: begin
                m_req  = 1'b1;
                m_wr   = 1'b1;
                m_addr = wdst_q + cnt_q;
                m_dout = buf_q;
                if (bus.m_grant) begin
                    if (cnt_q == wsize_q - 16'd1) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            int_en_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            wsrc_q   <= '0;
            wdst_q   <= '0;
            wsize_q  <= '0;
            buf_q    <= '0;
            s_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            size_q   <= size_d;
            int_en_q <= int_en_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            wsrc_q   <= wsrc_d;
            wdst_q   <= wdst_d;
            wsize_q  <= wsize_d;
            buf_q    <= buf_d;
            s_dout_q <= s_dout_d;
        end
    end

    assign bus.m_req  = m_req;
    assign bus.m_wr   = m_wr;
    assign bus.m_addr = m_addr;
    assign bus.m_dout = m_dout;
    assign bus.s_dout = s_dout_q;
    assign interrupt  = done_q & int_en_q;

endmodule
